// File: rtl/stream_mux2_arbiter.sv
// rtl/stream_mux2_arbiter.sv - two-input round-robin packet arbiter with a single registered output stage
module stream_mux2_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              locked
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e            state_q;
  logic              prio_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              sel_q;
  logic [DATA_W-1:0] out_data_q;

  logic              load_en;
  logic              grant_vld;
  logic              grant_src;
  logic              a_acc;
  logic              b_acc;
  logic              acc;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;

  // No skid buffer: a new beat can only enter when the register is empty or draining.
  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_src = 1'b0;
    case (state_q)
      LOCK_A: begin
        grant_vld = 1'b1;
        grant_src = 1'b0;
      end
      LOCK_B: begin
        grant_vld = 1'b1;
        grant_src = 1'b1;
      end
      default: begin
        if (a_valid && b_valid) begin
          grant_vld = 1'b1;
          grant_src = prio_q;
        end else if (a_valid) begin
          grant_vld = 1'b1;
          grant_src = 1'b0;
        end else if (b_valid) begin
          grant_vld = 1'b1;
          grant_src = 1'b1;
        end
      end
    endcase
  end

  assign a_ready  = load_en && grant_vld && !grant_src;
  assign b_ready  = load_en && grant_vld && grant_src;
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;
  assign acc      = a_acc || b_acc;
  assign acc_data = b_acc ? b_data : a_data;
  assign acc_last = b_acc ? b_last : a_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      if (load_en) begin
        out_valid_q <= acc;
      end
      if (acc) begin
        out_data_q <= acc_data;
        out_last_q <= acc_last;
        sel_q      <= b_acc;
        // Finishing a packet hands priority to the other source.
        if (acc_last) begin
          state_q <= IDLE;
          prio_q  <= !b_acc;
        end else begin
          state_q <= b_acc ? LOCK_B : LOCK_A;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;
  assign locked    = (state_q != IDLE);

endmodule

// File: tb/tb_stream_mux2_arbiter.sv
// tb/tb_stream_mux2_arbiter.sv - directed scoreboard bench for stream_mux2_arbiter
module tb_stream_mux2_arbiter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, a_last, a_ready;
  logic              b_valid, b_last, b_ready;
  logic [DATA_W-1:0] a_data, b_data, out_data;
  logic              out_valid, out_last, out_ready, sel, locked;

  int checks = 0;
  int failures = 0;

  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  logic [9:0] exp_q[$];
  logic       a_en = 1'b1;
  logic       b_en = 1'b1;
  logic       a_rdy_s, b_rdy_s, a_hs_s, b_hs_s, locked_s;
  int         n;

  always #5 clk = ~clk;

  stream_mux2_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .locked(locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    a_valid = a_en && (a_q.size() != 0);
    {a_last, a_data} = (a_q.size() != 0) ? a_q[0] : 9'h0;
    b_valid = b_en && (b_q.size() != 0);
    {b_last, b_data} = (b_q.size() != 0) ? b_q[0] : 9'h0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick();
    drive();
    #1;
    a_rdy_s  = a_ready;
    b_rdy_s  = b_ready;
    locked_s = locked;
    a_hs_s   = a_valid && a_ready;
    b_hs_s   = b_valid && b_ready;
    if (out_valid && out_ready) begin
      chk("beat_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("out_beat", 32'({sel, out_last, out_data}), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (a_hs_s) void'(a_q.pop_front());
    if (b_hs_s) void'(b_q.pop_front());
    @(negedge clk);
  endtask

  task automatic drain(input string tag, output int cnt);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    rst_n = 1'b1;

    // Fairness: single-beat packets on both sources alternate, one beat per cycle.
    for (int i = 0; i < 4; i++) begin
      a_q.push_back({1'b1, 8'h11});
      b_q.push_back({1'b1, 8'h22});
      exp_q.push_back({1'b0, 1'b1, 8'h11});
      exp_q.push_back({1'b1, 1'b1, 8'h22});
    end
    drain("fair_drain", n);
    chk("fair_cycles", 32'(n), 32'd9);

    // Packet lock: B is held off until A's last beat, then follows immediately.
    a_q = '{{1'b0, 8'hA0}, {1'b0, 8'hA1}, {1'b1, 8'hA2}};
    b_q = '{{1'b1, 8'hB0}};
    exp_q = '{{1'b0, 1'b0, 8'hA0}, {1'b0, 1'b0, 8'hA1}, {1'b0, 1'b1, 8'hA2}, {1'b1, 1'b1, 8'hB0}};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_a_hs", 32'(a_hs_s), 32'd1);
      chk("lock_b_ready", 32'(b_rdy_s), 32'd0);
      chk("lock_locked", 32'(locked_s), 32'(i != 0));
    end
    tick();
    chk("lock_b_hs", 32'(b_hs_s), 32'd1);
    chk("lock_idle", 32'(locked_s), 32'd0);
    drain("lock_drain", n);

    // Backpressure: output register holds, no input accepted, then releases in order.
    out_ready = 1'b0;
    a_q = '{{1'b1, 8'h5A}};
    b_q = '{{1'b1, 8'hC3}};
    exp_q = '{{1'b0, 1'b1, 8'h5A}, {1'b1, 1'b1, 8'hC3}};
    tick();
    chk("bp_a_hs", 32'(a_hs_s), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({sel, out_last, out_data}), 32'({1'b0, 1'b1, 8'h5A}));
      chk("bp_b_ready", 32'(b_rdy_s), 32'd0);
    end
    out_ready = 1'b1;
    drain("bp_drain", n);
    chk("bp_cycles", 32'(n), 32'd2);

    // Mid-packet bubble on B keeps the lock; A waits until B1 is accepted.
    a_q = '{{1'b1, 8'h44}, {1'b1, 8'h55}};
    b_q = '{{1'b0, 8'hB0}, {1'b1, 8'hB1}};
    exp_q = '{{1'b0, 1'b1, 8'h44}, {1'b1, 1'b0, 8'hB0}, {1'b1, 1'b1, 8'hB1}, {1'b0, 1'b1, 8'h55}};
    tick();
    chk("bub_a_first", 32'(a_hs_s), 32'd1);
    tick();
    chk("bub_b0_hs", 32'(b_hs_s), 32'd1);
    b_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_a_ready", 32'(a_rdy_s), 32'd0);
      chk("bub_locked", 32'(locked_s), 32'd1);
    end
    b_en = 1'b1;
    tick();
    chk("bub_b1_hs", 32'(b_hs_s), 32'd1);
    chk("bub_b1_a_ready", 32'(a_rdy_s), 32'd0);
    tick();
    chk("bub_a_after", 32'(a_hs_s), 32'd1);
    drain("bub_drain", n);

    // Reset mid-packet: the partial A packet is dropped, state and priority clear.
    a_q = '{{1'b0, 8'h66}};
    tick();
    chk("mr_a_hs", 32'(a_hs_s), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", 32'(out_data), 32'd0);
    chk("mr_sel", 32'(sel), 32'd0);
    chk("mr_locked", 32'(locked), 32'd0);
    a_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    b_q = '{{1'b1, 8'h33}};
    exp_q = '{{1'b1, 1'b1, 8'h33}};
    tick();
    chk("mr_b_hs", 32'(b_hs_s), 32'd1);
    drain("mr_b_drain", n);
    a_q = '{{1'b1, 8'h88}};
    b_q = '{{1'b1, 8'h99}};
    a_q.push_front({1'b1, 8'h77});
    b_q.delete();
    exp_q = '{{1'b0, 1'b1, 8'h77}};
    drain("mr_a_drain", n);
    a_q.delete();
    b_q.delete();

    // Priority after reset: A favoured when both arrive together.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    a_q = '{{1'b1, 8'h88}};
    b_q = '{{1'b1, 8'h99}};
    exp_q = '{{1'b0, 1'b1, 8'h88}, {1'b1, 1'b1, 8'h99}};
    tick();
    chk("prio_rst_a_first", 32'(a_hs_s), 32'd1);
    drain("prio_drain", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_mux2_arbiter.md
Name: stream_mux2_arbiter

Overview:
- Two-input packet arbiter feeding the design's 2:1 data mux stage.
- Accepts two valid/ready streams (A, B) and grants one packet at a time with round-robin fairness.
- Holds the grant until the beat marked last, then forwards the selected beats through one output register.
- Exports the registered select so the downstream 2:1 mux and monitors can see which source owns each output beat.

Parameters:
DATA_W, 8, width of a_data, b_data and out_data

Ports:
clk        input   1       rising-edge clock
rst_n      input   1       asynchronous active-low reset
a_valid    input   1       channel A beat valid
a_data     input   DATA_W  channel A beat data
a_last     input   1       channel A final beat of packet
a_ready    output  1       channel A beat accepted when a_valid && a_ready
b_valid    input   1       channel B beat valid
b_data     input   DATA_W  channel B beat data
b_last     input   1       channel B final beat of packet
b_ready    output  1       channel B beat accepted when b_valid && b_ready
out_valid  output  1       output beat valid (registered)
out_data   output  DATA_W  output beat data (registered)
out_last   output  1       output final beat (registered)
out_ready  input   1       downstream accepts beat when out_valid && out_ready
sel        output  1       source of current output beat: 0=A, 1=B (registered)
locked     output  1       1 while a packet is mid-transfer (state != IDLE)

Behaviour:
- Reset is asserted asynchronously when rst_n=0 and released synchronously to clk. Reset values: out_valid=0, out_data=0, out_last=0, sel=0, state=IDLE, prio=0 (A favoured).
- States: IDLE, LOCK_A, LOCK_B.
- load_en = !out_valid || out_ready. This is a single output register with no skid buffer, so throughput is 1 beat/cycle while out_ready=1.
- Grant (combinational):
  - IDLE: only A valid -> A; only B valid -> B; both valid -> A if prio=0, else B; neither valid -> none.
  - LOCK_A -> A. LOCK_B -> B, regardless of the other channel's valid.
- a_ready = load_en && grant==A. b_ready = load_en && grant==B. A non-granted channel's ready is 0.
  - In IDLE, ready may depend combinationally on the other channel's valid.
  - Ready never depends on out_data.
- On an accepted beat, at the next edge:
  - out_valid=1; out_data/out_last take the source's data/last; sel=source.
  - Latency is 1 cycle from input handshake to out_valid.
- On load_en with no accepted beat: out_valid=0. out_data, out_last and sel hold their last values.
- While out_valid && !out_ready: out_valid, out_data, out_last and sel all hold. Both readys are 0.
- State transitions on an accepted beat:
  - last=0: go to LOCK_src; prio unchanged.
  - last=1: go to IDLE; prio = !src, so the other channel is favoured next.
  - A single-beat packet (last=1 on the first beat) goes IDLE->IDLE and still toggles prio.
- With no accepted beat the state holds. Mid-packet bubbles (source valid=0 while LOCKed) keep the lock; the other channel stays blocked.
- Back-to-back packets: a new packet is granted in the cycle right after the last beat is accepted, with no idle cycle required.
- locked = (state != IDLE).
- Reset mid-packet: everything returns to reset values immediately and the partial packet is dropped. Realigning packets afterwards is upstream's responsibility.
- Simultaneous out_ready and new input in the same cycle: the register is drained and reloaded in one cycle with no bubble.
- Valid/data on a non-granted channel are ignored and never corrupt out_data.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, sel=0, locked=0 immediately. After release, with both valid and single-beat packets, A is granted first.
- Fairness: A and B continuously valid, single-beat packets A=0x11, B=0x22, out_ready=1 -> output 0x11,0x22,0x11,0x22..., sel toggles 0,1,0,1, one beat per cycle.
- Packet lock: A sends a 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2) while B is valid with 0xB0 throughout -> b_ready=0 until 0xA2 is accepted, output 0xA0,0xA1,0xA2,0xB0, locked=1 for the first two accepted beats.
- Backpressure: out_ready=0 for 4 cycles with out_data=0x5A held -> out_data/out_last/sel stable, a_ready=b_ready=0. Then out_ready=1 -> the next beat appears one cycle later with no loss or duplication.
- Mid-packet bubble: B sends 0xB0 (last=0), b_valid=0 for 3 cycles, then 0xB1 (last=1), with A valid throughout -> a_ready stays 0 until 0xB1 is accepted; A is granted the following cycle.
- Reset mid-packet: after A's first beat (last=0), pulse rst_n low -> state=IDLE, prio=0. B then sends a single beat 0x33 -> it is granted immediately.
